// File: rtl/rename_stage_if.sv
// rename_stage_if: bundles the decode-side instruction handshake, the ROB
// retire/free slots and the renamed-instruction outputs of the rename stage.
// master = upstream/ROB side driving the stage, slave = the rename stage.
interface rename_stage_if #(
  parameter int AREG_W = 5,
  parameter int TAG_W  = 6
);
  logic              in_valid;
  logic [AREG_W-1:0] in_rs1;
  logic [AREG_W-1:0] in_rs2;
  logic [AREG_W-1:0] in_rd;
  logic              in_rd_wr;
  logic              stall_in;
  logic              free_valid_0;
  logic [TAG_W-1:0]  free_tag_0;
  logic              free_valid_1;
  logic [TAG_W-1:0]  free_tag_1;
  logic              stall;
  logic              out_valid;
  logic [TAG_W-1:0]  out_prs1;
  logic [TAG_W-1:0]  out_prs2;
  logic [TAG_W-1:0]  out_prd;
  logic [TAG_W-1:0]  out_old_prd;
  logic              out_rd_wr;
  logic [TAG_W-1:0]  free_count;
  logic              err_overflow;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_wr, stall_in,
           free_valid_0, free_tag_0, free_valid_1, free_tag_1,
    input  stall, out_valid, out_prs1, out_prs2, out_prd, out_old_prd,
           out_rd_wr, free_count, err_overflow
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wr, stall_in,
           free_valid_0, free_tag_0, free_valid_1, free_tag_1,
    output stall, out_valid, out_prs1, out_prs2, out_prd, out_old_prd,
           out_rd_wr, free_count, err_overflow
  );
endinterface

// File: rtl/rename_stage.sv
// rename_stage: register-rename stage feeding the reorder buffer.
// Maps rs1/rs2/rd through a register alias table and hands out new physical
// destinations from a circular free list; up to two retired tags are pushed
// back per cycle. Optional feature macro: RENAME_FREE_BYPASS_EN -- when the
// list is empty, a tag freed on slot 0 is handed straight to the instruction.
module rename_stage #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int TAG_W     = 6,
  parameter int FL_DEPTH  = 32
) (
  input logic           clk,
  input logic           rst,
  rename_stage_if.slave rif
);
  localparam int FL_W = $clog2(FL_DEPTH);
  localparam logic [TAG_W-1:0] TAG_ZERO = {TAG_W{1'b0}};
  localparam logic [TAG_W-1:0] FL_FULL  = TAG_W'(FL_DEPTH);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FL_DEPTH - 1);

  // Circular pointer increment; wraps at FL_DEPTH even if not a power of two.
  function automatic logic [FL_W-1:0] fl_inc(input logic [FL_W-1:0] ptr);
    if (ptr == FL_LAST) fl_inc = {FL_W{1'b0}};
    else                fl_inc = ptr + {{(FL_W-1){1'b0}}, 1'b1};
  endfunction

  logic [TAG_W-1:0] rat_r [ARCH_REGS];
  logic [TAG_W-1:0] fl_r  [FL_DEPTH];
  logic [FL_W-1:0]  head_r, tail_r;
  logic [TAG_W-1:0] count_r;
  logic             out_valid_r, out_rd_wr_r, err_overflow_r;
  logic [TAG_W-1:0] out_prs1_r, out_prs2_r, out_prd_r, out_old_prd_r;

  logic             need_alloc_s, list_empty_s, bypass_ok_s, stall_s, accept_s;
  logic             alloc_s, use_bypass_s, alloc_list_s;
  logic [TAG_W-1:0] alloc_tag_s, prs1_s, prs2_s, old_prd_s;
  logic [TAG_W-1:0] cnt_after_alloc_s, cnt_mid_s, count_next_s;
  logic             f0_req_s, f0_wr_s, f0_ovf_s, f1_req_s, f1_wr_s, f1_ovf_s;
  logic [FL_W-1:0]  slot1_idx_s, tail_next_s, head_next_s;

  // Rename decision, allocation source and free-list write slots for this cycle.
  always_comb begin
    need_alloc_s = rif.in_valid & rif.in_rd_wr & (rif.in_rd != {$bits(rif.in_rd){1'b0}});
    list_empty_s = (count_r == TAG_ZERO);
`ifdef RENAME_FREE_BYPASS_EN
    bypass_ok_s  = list_empty_s & rif.free_valid_0 & (rif.free_tag_0 != TAG_ZERO);
`else
    bypass_ok_s  = 1'b0;
`endif
    stall_s      = rif.stall_in | (need_alloc_s & list_empty_s & ~bypass_ok_s);
    accept_s     = rif.in_valid & ~stall_s;
    alloc_s      = accept_s & need_alloc_s;
    use_bypass_s = alloc_s & bypass_ok_s;
    alloc_list_s = alloc_s & ~use_bypass_s;

    if (use_bypass_s) alloc_tag_s = rif.free_tag_0;
    else              alloc_tag_s = fl_r[head_r];

    // x0 is hard-wired to p0 regardless of table contents.
    if (rif.in_rs1 == {$bits(rif.in_rs1){1'b0}}) prs1_s = TAG_ZERO;
    else                                         prs1_s = rat_r[rif.in_rs1];
    if (rif.in_rs2 == {$bits(rif.in_rs2){1'b0}}) prs2_s = TAG_ZERO;
    else                                         prs2_s = rat_r[rif.in_rs2];
    old_prd_s = rat_r[rif.in_rd];

    // Capacity for frees is judged after this cycle's allocation.
    cnt_after_alloc_s = count_r - {{(TAG_W-1){1'b0}}, alloc_list_s};
    f0_req_s  = rif.free_valid_0 & (rif.free_tag_0 != TAG_ZERO) & ~use_bypass_s;
    f0_wr_s   = f0_req_s & (cnt_after_alloc_s < FL_FULL);
    f0_ovf_s  = f0_req_s & ~f0_wr_s;
    cnt_mid_s = cnt_after_alloc_s + {{(TAG_W-1){1'b0}}, f0_wr_s};
    f1_req_s  = rif.free_valid_1 & (rif.free_tag_1 != TAG_ZERO);
    f1_wr_s   = f1_req_s & (cnt_mid_s < FL_FULL);
    f1_ovf_s  = f1_req_s & ~f1_wr_s;
    count_next_s = cnt_mid_s + {{(TAG_W-1){1'b0}}, f1_wr_s};

    if (f0_wr_s) slot1_idx_s = fl_inc(tail_r);
    else         slot1_idx_s = tail_r;
    if (f1_wr_s) tail_next_s = fl_inc(slot1_idx_s);
    else         tail_next_s = slot1_idx_s;
    if (alloc_list_s) head_next_s = fl_inc(head_r);
    else              head_next_s = head_r;
  end

  // Alias table, free-list storage and list pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat_r[i] <= TAG_W'(i);
      for (int j = 0; j < FL_DEPTH; j++)  fl_r[j]  <= TAG_W'(PHYS_REGS - FL_DEPTH + j);
      head_r  <= {FL_W{1'b0}};
      tail_r  <= {FL_W{1'b0}};
      count_r <= FL_FULL;
    end else begin
      if (alloc_s) rat_r[rif.in_rd] <= alloc_tag_s;
      if (f0_wr_s) fl_r[tail_r] <= rif.free_tag_0;
      if (f1_wr_s) fl_r[slot1_idx_s] <= rif.free_tag_1;
      head_r  <= head_next_s;
      tail_r  <= tail_next_s;
      count_r <= count_next_s;
    end
  end

  // Renamed-instruction output registers: load on accept, hold under stall_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r   <= 1'b0;
      out_prs1_r    <= TAG_ZERO;
      out_prs2_r    <= TAG_ZERO;
      out_prd_r     <= TAG_ZERO;
      out_old_prd_r <= TAG_ZERO;
      out_rd_wr_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_prs1_r  <= prs1_s;
      out_prs2_r  <= prs2_s;
      if (need_alloc_s) begin
        out_prd_r     <= alloc_tag_s;
        out_old_prd_r <= old_prd_s;
        out_rd_wr_r   <= 1'b1;
      end else begin
        out_prd_r     <= TAG_ZERO;
        out_old_prd_r <= TAG_ZERO;
        out_rd_wr_r   <= 1'b0;
      end
    end else if (!rif.stall_in) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky flag for a free that found the list already full.
  always_ff @(posedge clk) begin
    if (rst) err_overflow_r <= 1'b0;
    else     err_overflow_r <= err_overflow_r | f0_ovf_s | f1_ovf_s;
  end

  assign rif.stall        = stall_s;
  assign rif.out_valid    = out_valid_r;
  assign rif.out_prs1     = out_prs1_r;
  assign rif.out_prs2     = out_prs2_r;
  assign rif.out_prd      = out_prd_r;
  assign rif.out_old_prd  = out_old_prd_r;
  assign rif.out_rd_wr    = out_rd_wr_r;
  assign rif.free_count   = count_r;
  assign rif.err_overflow = err_overflow_r;
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed, table-driven bench for rename_stage, followed by
// hand-written sequences for list exhaustion, same-cycle alloc/free and overflow.
module tb_rename_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rename_stage_if rif ();
  rename_stage dut (.clk(clk), .rst(rst), .rif(rif));

  typedef struct {
    int v, rs1, rs2, rd, wr, sin, fv0, ft0, fv1, ft1;
    int e_stall, e_valid, e_prs1, e_prs2, e_prd, e_old, e_rdwr, e_count, e_err;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input int v, input int rs1, input int rs2, input int rd,
                        input int wr, input int sin, input int fv0, input int ft0,
                        input int fv1, input int ft1);
    rif.in_valid     = (v != 0);
    rif.in_rs1       = 5'(rs1);
    rif.in_rs2       = 5'(rs2);
    rif.in_rd        = 5'(rd);
    rif.in_rd_wr     = (wr != 0);
    rif.stall_in     = (sin != 0);
    rif.free_valid_0 = (fv0 != 0);
    rif.free_tag_0   = 6'(ft0);
    rif.free_valid_1 = (fv1 != 0);
    rif.free_tag_1   = 6'(ft1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string nm, input int ev, input int ep1, input int ep2,
                            input int epd, input int eold, input int erw, input int ecnt,
                            input int eerr);
    chk({nm, ".out_valid"},    int'(rif.out_valid),    ev);
    chk({nm, ".out_prs1"},     int'(rif.out_prs1),     ep1);
    chk({nm, ".out_prs2"},     int'(rif.out_prs2),     ep2);
    chk({nm, ".out_prd"},      int'(rif.out_prd),      epd);
    chk({nm, ".out_old_prd"},  int'(rif.out_old_prd),  eold);
    chk({nm, ".out_rd_wr"},    int'(rif.out_rd_wr),    erw);
    chk({nm, ".free_count"},   int'(rif.free_count),   ecnt);
    chk({nm, ".err_overflow"}, int'(rif.err_overflow), eerr);
  endtask

  initial begin
    //              v rs1 rs2 rd wr sin fv0 ft0 fv1 ft1 | stl val prs1 prs2 prd old rw cnt err
    vecs[0] = '{1, 5, 0, 5, 1, 0, 0, 0, 0, 0,   0, 1,  5,  0, 32,  5, 1, 31, 0};
    vecs[1] = '{1, 5, 3, 5, 1, 0, 0, 0, 0, 0,   0, 1, 32,  3, 33, 32, 1, 30, 0};
    vecs[2] = '{1, 5, 5, 0, 1, 0, 0, 0, 0, 0,   0, 1, 33, 33,  0,  0, 0, 30, 0};
    vecs[3] = '{1, 0, 7, 7, 0, 0, 0, 0, 0, 0,   0, 1,  0,  7,  0,  0, 0, 30, 0};
    vecs[4] = '{1, 5, 6, 6, 1, 1, 0, 0, 0, 0,   1, 1,  0,  7,  0,  0, 0, 30, 0};
    vecs[5] = '{1, 5, 6, 6, 1, 1, 1, 0, 0, 0,   1, 1,  0,  7,  0,  0, 0, 30, 0};
    vecs[6] = '{1, 5, 6, 6, 1, 1, 0, 0, 0, 0,   1, 1,  0,  7,  0,  0, 0, 30, 0};
    vecs[7] = '{1, 5, 6, 6, 1, 0, 0, 0, 0, 0,   0, 1, 33,  6, 34,  6, 1, 29, 0};
    vecs[8] = '{1, 6, 5, 6, 1, 0, 0, 0, 0, 0,   0, 1, 34, 33, 35, 34, 1, 28, 0};
    vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 34, 33, 35, 34, 1, 28, 0};

    // Reset dominates live inputs and frees.
    rst = 1'b1;
    set_in(1, 3, 4, 5, 1, 0, 1, 9, 1, 10);
    tick();
    tick();
    check_outs("reset", 0, 0, 0, 0, 0, 0, 32, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wr,
             vecs[i].sin, vecs[i].fv0, vecs[i].ft0, vecs[i].fv1, vecs[i].ft1);
      #1;
      chk($sformatf("vec%0d.stall", i), int'(rif.stall), vecs[i].e_stall);
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_prs1, vecs[i].e_prs2,
                 vecs[i].e_prd, vecs[i].e_old, vecs[i].e_rdwr, vecs[i].e_count,
                 vecs[i].e_err);
    end

    // Drain the list: 28 remaining tags come out in order 36..63.
    for (int i = 0; i < 28; i++) begin
      set_in(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
      tick();
      chk($sformatf("drain%0d.out_prd", i), int'(rif.out_prd), 36 + i);
    end
    chk("drain.free_count", int'(rif.free_count), 0);

    // Empty list stalls the allocating instruction.
    set_in(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    #1;
    chk("empty.stall", int'(rif.stall), 1);
    tick();
    chk("empty.out_valid", int'(rif.out_valid), 0);
    chk("empty.free_count", int'(rif.free_count), 0);

    // Tag 5 retires while the list is empty.
    set_in(1, 0, 0, 10, 1, 0, 1, 5, 0, 0);
    #1;
`ifdef RENAME_FREE_BYPASS_EN
    chk("bypass.stall", int'(rif.stall), 0);
    tick();
`else
    chk("refill.stall", int'(rif.stall), 1);
    tick();
    chk("refill.out_valid", int'(rif.out_valid), 0);
    chk("refill.free_count", int'(rif.free_count), 1);
    set_in(1, 0, 0, 10, 1, 0, 0, 0, 0, 0);
    #1;
    chk("refill.stall_next", int'(rif.stall), 0);
    tick();
`endif
    chk("reuse.out_valid", int'(rif.out_valid), 1);
    chk("reuse.out_prd", int'(rif.out_prd), 5);
    chk("reuse.out_old_prd", int'(rif.out_old_prd), 63);
    chk("reuse.free_count", int'(rif.free_count), 0);

    // count=1, then allocate while both slots free 7 and 9.
    set_in(0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
    tick();
    chk("one.free_count", int'(rif.free_count), 1);
    set_in(1, 0, 0, 11, 1, 0, 1, 7, 1, 9);
    #1;
    chk("dual.stall", int'(rif.stall), 0);
    tick();
    chk("dual.out_prd", int'(rif.out_prd), 20);
    chk("dual.free_count", int'(rif.free_count), 2);
    set_in(1, 0, 0, 11, 1, 0, 0, 0, 0, 0);
    tick();
    chk("order0.out_prd", int'(rif.out_prd), 7);
    chk("order0.free_count", int'(rif.free_count), 1);
    tick();
    chk("order1.out_prd", int'(rif.out_prd), 9);
    chk("order1.free_count", int'(rif.free_count), 0);
    chk("order1.out_old_prd", int'(rif.out_old_prd), 7);

    // Full list: alloc + two frees, second free is dropped.
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    set_in(1, 0, 0, 5, 1, 0, 1, 40, 1, 41);
    tick();
    chk("ovf_alloc.out_prd", int'(rif.out_prd), 32);
    chk("ovf_alloc.free_count", int'(rif.free_count), 32);
    chk("ovf_alloc.err_overflow", int'(rif.err_overflow), 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("ovf_sticky.err_overflow", int'(rif.err_overflow), 1);

    // Reset clears the sticky flag, then a plain free at count=32 overflows.
    rst = 1'b1;
    set_in(1, 1, 2, 3, 1, 0, 1, 12, 0, 0);
    tick();
    check_outs("reset2", 0, 0, 0, 0, 0, 0, 32, 0);
    rst = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 1, 12, 0, 0);
    tick();
    chk("ovf_free.err_overflow", int'(rif.err_overflow), 1);
    chk("ovf_free.free_count", int'(rif.free_count), 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
